// File: rtl/linear_array_tile_sequencer.sv
// rtl/linear_array_tile_sequencer.sv - per-tile beat gating, tlast generation and drain tracking
// for the linear processing array's left (data) and top (weight) inputs.
module linear_array_tile_sequencer #(
  parameter int PE_NUMBER_I   = 1,
  parameter int PE_NUMBER_J   = 1,
  parameter int BATCH_SIZE    = 1,
  parameter int LEN_WIDTH     = 16,
  parameter int TILE_WIDTH    = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [LEN_WIDTH-1:0]                cmd_len,
  input  logic [TILE_WIDTH-1:0]               cmd_tiles,
  input  logic [PE_NUMBER_J*BATCH_SIZE-1:0]   s_l_tvalid,
  output logic [PE_NUMBER_J*BATCH_SIZE-1:0]   s_l_tready,
  output logic [PE_NUMBER_J*BATCH_SIZE-1:0]   m_l_tvalid,
  input  logic [PE_NUMBER_J*BATCH_SIZE-1:0]   m_l_tready,
  output logic [PE_NUMBER_J*BATCH_SIZE-1:0]   m_l_tlast,
  input  logic [PE_NUMBER_I*PE_NUMBER_J-1:0]  s_t_tvalid,
  output logic [PE_NUMBER_I*PE_NUMBER_J-1:0]  s_t_tready,
  output logic [PE_NUMBER_I*PE_NUMBER_J-1:0]  m_t_tvalid,
  input  logic [PE_NUMBER_I*PE_NUMBER_J-1:0]  m_t_tready,
  output logic [PE_NUMBER_I*PE_NUMBER_J-1:0]  m_t_tlast,
  input  logic [PE_NUMBER_I*BATCH_SIZE-1:0]   d_tvalid,
  input  logic [PE_NUMBER_I*BATCH_SIZE-1:0]   d_tready,
  input  logic [PE_NUMBER_I*BATCH_SIZE-1:0]   d_tlast,
  input  logic                                err_unalligned_data,
  input  logic                                core_rst,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [TILE_WIDTH-1:0]               tile_cnt
);

  localparam int NL = PE_NUMBER_J * BATCH_SIZE;
  localparam int NT = PE_NUMBER_I * PE_NUMBER_J;
  localparam int ND = PE_NUMBER_I * BATCH_SIZE;
  localparam int DW = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = 1;
  localparam logic [TILE_WIDTH-1:0] TILE_ONE   = 1;
  localparam logic [DW-1:0]         DRAIN_ONE  = 1;
  localparam logic [DW-1:0]         DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE, S_ERROR} state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [TILE_WIDTH-1:0] tiles_q;
  logic [TILE_WIDTH-1:0] tile_cnt_q;
  logic [LEN_WIDTH-1:0]  l_beat [NL];
  logic [LEN_WIDTH-1:0]  t_beat [NT];
  logic [ND-1:0]         out_mask, out_mask_nxt;
  logic [DW-1:0]         drain_cnt;
  logic                  err_q;
  logic [NL-1:0]         l_open;
  logic [NT-1:0]         t_open;
  logic                  all_fed, tile_done, fault, accept;

  assign fault     = err_unalligned_data | core_rst;
  assign accept    = (state == S_IDLE) & cmd_valid;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign tile_cnt  = tile_cnt_q;

  genvar gx;
  for (gx = 0; gx < NL; gx++) begin : g_l
    assign l_open[gx]     = (state == S_FEED) && (l_beat[gx] < len_q);
    assign m_l_tvalid[gx] = s_l_tvalid[gx] & l_open[gx];
    assign s_l_tready[gx] = m_l_tready[gx] & l_open[gx];
    assign m_l_tlast[gx]  = l_open[gx] && (l_beat[gx] == len_q - LEN_ONE);
  end
  for (gx = 0; gx < NT; gx++) begin : g_t
    assign t_open[gx]     = (state == S_FEED) && (t_beat[gx] < len_q);
    assign m_t_tvalid[gx] = s_t_tvalid[gx] & t_open[gx];
    assign s_t_tready[gx] = m_t_tready[gx] & t_open[gx];
    assign m_t_tlast[gx]  = t_open[gx] && (t_beat[gx] == len_q - LEN_ONE);
  end

  // Registered counters only, so the FEED->DRAIN hop lands one cycle after the last beat.
  always_comb begin
    all_fed = 1'b1;
    for (int x = 0; x < NL; x++) if (l_beat[x] != len_q) all_fed = 1'b0;
    for (int x = 0; x < NT; x++) if (t_beat[x] != len_q) all_fed = 1'b0;
  end

  always_comb begin
    state_nxt    = state;
    tile_done    = 1'b0;
    out_mask_nxt = out_mask | (d_tvalid & d_tready & d_tlast);
    case (state)
      S_IDLE:
        if (cmd_valid) state_nxt = (cmd_len == '0 || cmd_tiles == '0) ? S_DONE : S_FEED;
      S_FEED:
        if (fault)        state_nxt = S_ERROR;
        else if (all_fed) state_nxt = S_DRAIN;
      S_DRAIN:
        if (fault) state_nxt = S_ERROR;
        else if (&out_mask_nxt) begin
          tile_done = 1'b1;
          state_nxt = (tile_cnt_q + TILE_ONE == tiles_q) ? S_DONE : S_FEED;
        end else if (drain_cnt == DRAIN_LAST) state_nxt = S_ERROR;
      S_DONE:  state_nxt = S_IDLE;
      S_ERROR:
        if (!err_unalligned_data && !core_rst) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      tiles_q    <= '0;
      tile_cnt_q <= '0;
      out_mask   <= '0;
      drain_cnt  <= '0;
      err_q      <= 1'b0;
      for (int x = 0; x < NL; x++) l_beat[x] <= '0;
      for (int x = 0; x < NT; x++) t_beat[x] <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DRAIN_ONE : '0;
      if (state_nxt == S_ERROR) err_q <= 1'b1;
      if (accept) begin
        len_q      <= cmd_len;
        tiles_q    <= cmd_tiles;
        tile_cnt_q <= '0;
        out_mask   <= '0;
        err_q      <= 1'b0;
        for (int x = 0; x < NL; x++) l_beat[x] <= '0;
        for (int x = 0; x < NT; x++) t_beat[x] <= '0;
      end else if (tile_done) begin
        tile_cnt_q <= tile_cnt_q + TILE_ONE;
        out_mask   <= '0;
        for (int x = 0; x < NL; x++) l_beat[x] <= '0;
        for (int x = 0; x < NT; x++) t_beat[x] <= '0;
      end else begin
        if (state == S_FEED || state == S_DRAIN) out_mask <= out_mask_nxt;
        for (int x = 0; x < NL; x++)
          if (m_l_tvalid[x] && m_l_tready[x]) l_beat[x] <= l_beat[x] + LEN_ONE;
        for (int x = 0; x < NT; x++)
          if (m_t_tvalid[x] && m_t_tready[x]) t_beat[x] <= t_beat[x] + LEN_ONE;
      end
    end
  end

endmodule
